instr_issuer: RTL and testbench

//   Sender side of the processor's instruction interface: buffers instructions
//   {func, input1, input2} in a FIFO and drives them to the control state

---
 rtl/instr_issuer.sv | 217 +++++++++++++++++++++
 tb/tb_instr_issuer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issuer.sv
// Instruction issuer: queues {func,input1,input2} and hands them to the controller one at a time.
// Latency: a push into an empty, idle issuer reaches the outputs 2 cycles later; minimum 3 cycles per instruction.
// Backpressure: no ready signal; a push while full is dropped and raises the sticky overflow flag.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   wr_en, wr_func, wr_in1, wr_in2   instruction push
//   done                             controller finished the current instruction
//   clr_err                          clears overflow / timeout_err
//   func, input1, input2             instruction to controller (all zero when idle)
//   issue_valid                      1-cycle pulse when a new instruction appears
//   busy                             instruction outstanding
//   full, empty, count               FIFO status
//   overflow, timeout_err            sticky error flags

// Generic synchronous FIFO: push is ignored while full, pop is ignored while empty.
// Latency: read data is the current head, combinational from storage.
// Backpressure: caller observes full/empty; no internal stall.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_dat,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_dat  = mem[rd_ptr];

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module instr_issuer #(
    parameter int DEPTH   = 8,
    parameter int FUNC_W  = 4,
    parameter int FIELD_W = 3,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [FUNC_W-1:0]      wr_func,
    input  logic [FIELD_W-1:0]     wr_in1,
    input  logic [FIELD_W-1:0]     wr_in2,
    input  logic                   done,
    input  logic                   clr_err,
    output logic [FUNC_W-1:0]      func,
    output logic [FIELD_W-1:0]     input1,
    output logic [FIELD_W-1:0]     input2,
    output logic                   issue_valid,
    output logic                   busy,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   timeout_err
);
    localparam int INSTR_W = FUNC_W + 2 * FIELD_W;
    localparam int CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [INSTR_W-1:0]   head_dat;
    logic                 pop;
    logic [FUNC_W-1:0]    func_nxt;
    logic [FIELD_W-1:0]   in1_nxt;
    logic [FIELD_W-1:0]   in2_nxt;
    logic                 iv_nxt;
    logic                 busy_nxt;
    logic [CNT_W-1:0]     wait_cnt;
    logic [CNT_W-1:0]     wait_cnt_nxt;
    logic                 timeout_evt;
    logic                 ovf_nxt;
    logic                 terr_nxt;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (wr_en),
        .pop    (pop),
        .wr_dat ({wr_func, wr_in1, wr_in2}),
        .rd_dat (head_dat),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    always_comb begin
        state_nxt    = state;
        func_nxt     = func;
        in1_nxt      = input1;
        in2_nxt      = input2;
        iv_nxt       = 1'b0;
        busy_nxt     = busy;
        wait_cnt_nxt = wait_cnt;
        pop          = 1'b0;
        timeout_evt  = 1'b0;
        case (state)
            IDLE: begin
                func_nxt = '0;
                in1_nxt  = '0;
                in2_nxt  = '0;
                busy_nxt = 1'b0;
                if (!empty) begin
                    pop                          = 1'b1;
                    {func_nxt, in1_nxt, in2_nxt} = head_dat;
                    iv_nxt                       = 1'b1;
                    busy_nxt                     = 1'b1;
                    state_nxt                    = ISSUE;
                end
            end
            ISSUE: begin
                // done is ignored here; the wait window starts at 1 on entry to WAIT.
                wait_cnt_nxt = CNT_W'(1);
                state_nxt    = WAIT;
            end
            WAIT: begin
                // done is checked before the limit, so it wins on the final cycle.
                if (done) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    func_nxt  = '0;
                    in1_nxt   = '0;
                    in2_nxt   = '0;
                end else if (wait_cnt == TIMEOUT_C) begin
                    timeout_evt = 1'b1;
                    state_nxt   = IDLE;
                    busy_nxt    = 1'b0;
                    func_nxt    = '0;
                    in1_nxt     = '0;
                    in2_nxt     = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A fresh error outranks a simultaneous clear.
        ovf_nxt  = (wr_en && full) ? 1'b1 : (clr_err ? 1'b0 : overflow);
        terr_nxt = timeout_evt ? 1'b1 : (clr_err ? 1'b0 : timeout_err);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            func        <= '0;
            input1      <= '0;
            input2      <= '0;
            issue_valid <= 1'b0;
            busy        <= 1'b0;
            wait_cnt    <= '0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            func        <= func_nxt;
            input1      <= in1_nxt;
            input2      <= in2_nxt;
            issue_valid <= iv_nxt;
            busy        <= busy_nxt;
            wait_cnt    <= wait_cnt_nxt;
            overflow    <= ovf_nxt;
            timeout_err <= terr_nxt;
        end
    end
endmodule

// File: tb/tb_instr_issuer.sv
// Self-checking bench for instr_issuer: directed vector table, directed
// multi-cycle sequences, then random traffic against a queue-based model.
module tb_instr_issuer;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_func = '0;
    logic [2:0] wr_in1 = '0;
    logic [2:0] wr_in2 = '0;
    logic       done = 1'b0;
    logic       clr_err = 1'b0;
    logic [3:0] func;
    logic [2:0] input1;
    logic [2:0] input2;
    logic       issue_valid;
    logic       busy;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       overflow;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    instr_issuer #(
        .DEPTH   (DEPTH),
        .FUNC_W  (4),
        .FIELD_W (3),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_func     (wr_func),
        .wr_in1      (wr_in1),
        .wr_in2      (wr_in2),
        .done        (done),
        .clr_err     (clr_err),
        .func        (func),
        .input1      (input1),
        .input2      (input2),
        .issue_valid (issue_valid),
        .busy        (busy),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    logic [19:0] obs;
    assign obs = {func, input1, input2, issue_valid, busy, count, full, empty, overflow, timeout_err};

    // ---------------- behavioural reference model ----------------
    // Pending instructions live in a queue; the outstanding one is tracked by
    // its age in cycles since it was issued.
    logic [9:0] mq[$];
    logic [9:0] m_out = '0;
    logic       m_iv = 1'b0;
    logic       m_busy = 1'b0;
    int         m_age = 0;
    logic       m_ovf = 1'b0;
    logic       m_terr = 1'b0;
    logic       m_full_b;
    logic       m_terr_evt;

    always @(posedge clk) begin
        m_full_b   = (mq.size() == DEPTH);
        m_terr_evt = 1'b0;
        if (!rst_n) begin
            mq.delete();
            m_out  = '0;
            m_iv   = 1'b0;
            m_busy = 1'b0;
            m_age  = 0;
            m_ovf  = 1'b0;
            m_terr = 1'b0;
        end else begin
            m_iv = 1'b0;
            if (m_busy) begin
                if (m_age == 0) begin
                    m_age = 1;
                end else if (done) begin
                    m_busy = 1'b0;
                    m_out  = '0;
                end else if (m_age == TIMEOUT) begin
                    m_busy     = 1'b0;
                    m_out      = '0;
                    m_terr_evt = 1'b1;
                end else begin
                    m_age = m_age + 1;
                end
            end else if (mq.size() > 0) begin
                m_out  = mq.pop_front();
                m_busy = 1'b1;
                m_age  = 0;
                m_iv   = 1'b1;
            end
            if (wr_en && !m_full_b) mq.push_back({wr_func, wr_in1, wr_in2});
            m_ovf  = (wr_en && m_full_b) ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
            m_terr = m_terr_evt ? 1'b1 : (clr_err ? 1'b0 : m_terr);
        end
    end

    function automatic logic [19:0] model_obs();
        logic [3:0] c;
        c = 4'(mq.size());
        return {m_out, m_iv, m_busy, c, c == 4'(DEPTH), c == 4'd0, m_ovf, m_terr};
    endfunction

    // ---------------- helpers ----------------
    logic [9:0] issued[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic [3:0] f, input logic [2:0] a, input logic [2:0] b,
                       input logic d, input logic c);
        @(negedge clk);
        wr_en = w; wr_func = f; wr_in1 = a; wr_in2 = b; done = d; clr_err = c;
        @(posedge clk);
        #1;
        if (issue_valid === 1'b1) issued.push_back({func, input1, input2});
    endtask

    task automatic idle_cyc(input logic d, input logic c);
        cyc(1'b0, 4'd0, 3'd0, 3'd0, d, c);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b1, 4'hF, 3'd7, 3'd7, 1'b0, 1'b0);
        cyc(1'b1, 4'hF, 3'd7, 3'd7, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       r, w, d, c;
        logic [3:0] f;
        logic [2:0] a, b;
        logic [3:0] ef;
        logic [2:0] ea, eb;
        logic       eiv, ebusy;
        logic [3:0] ecnt;
        logic       eovf, eterr;
    } vec_t;

    function automatic vec_t mk(logic r, logic w, logic [3:0] f, logic [2:0] a, logic [2:0] b,
                                logic d, logic c, logic [3:0] ef, logic [2:0] ea, logic [2:0] eb,
                                logic eiv, logic ebusy, logic [3:0] ecnt, logic eovf, logic eterr);
        vec_t v;
        v.r = r; v.w = w; v.f = f; v.a = a; v.b = b; v.d = d; v.c = c;
        v.ef = ef; v.ea = ea; v.eb = eb; v.eiv = eiv; v.ebusy = ebusy;
        v.ecnt = ecnt; v.eovf = eovf; v.eterr = eterr;
        return v;
    endfunction

    vec_t       vt[14];
    logic [9:0] ord[4];
    logic [19:0] expv;
    int         n;
    int         dp;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //          r  w  f  a  b  d  c   ef ea eb iv bsy cnt ovf terr
        vt[0]  = mk(0, 1, 5, 1, 1, 0, 0,  0, 0, 0, 0, 0,  0,  0,  0); // reset with push
        vt[1]  = mk(0, 1, 5, 1, 1, 0, 0,  0, 0, 0, 0, 0,  0,  0,  0);
        vt[2]  = mk(1, 1, 1, 0, 3, 0, 0,  0, 0, 0, 0, 0,  1,  0,  0); // push
        vt[3]  = mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 3, 1, 1,  0,  0,  0); // issued 2 cycles on
        vt[4]  = mk(1, 0, 0, 0, 0, 1, 0,  1, 0, 3, 0, 1,  0,  0,  0); // done ignored in ISSUE
        vt[5]  = mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 3, 0, 1,  0,  0,  0);
        vt[6]  = mk(1, 1, 2, 1, 5, 1, 0,  0, 0, 0, 0, 0,  1,  0,  0); // done + push
        vt[7]  = mk(1, 1, 3, 2, 6, 0, 0,  2, 1, 5, 1, 1,  1,  0,  0); // push with pop
        vt[8]  = mk(1, 0, 0, 0, 0, 0, 0,  2, 1, 5, 0, 1,  1,  0,  0);
        vt[9]  = mk(1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0,  1,  0,  0);
        vt[10] = mk(1, 0, 0, 0, 0, 0, 0,  3, 2, 6, 1, 1,  0,  0,  0);
        vt[11] = mk(1, 0, 0, 0, 0, 0, 1,  3, 2, 6, 0, 1,  0,  0,  0);
        vt[12] = mk(1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0,  0,  0,  0);
        vt[13] = mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0,  0,  0);

        for (int i = 0; i < 14; i++) begin
            rst_n = vt[i].r;
            cyc(vt[i].w, vt[i].f, vt[i].a, vt[i].b, vt[i].d, vt[i].c);
            expv = {vt[i].ef, vt[i].ea, vt[i].eb, vt[i].eiv, vt[i].ebusy, vt[i].ecnt,
                    vt[i].ecnt == 4'd8, vt[i].ecnt == 4'd0, vt[i].eovf, vt[i].eterr};
            chk($sformatf("vec%0d", i), 32'(obs), 32'(expv));
        end

        // ---- queue order: 4 instructions, done held high ----
        ord[0] = {4'b0001, 3'b000, 3'b011};
        ord[1] = {4'b0001, 3'b001, 3'b101};
        ord[2] = {4'b0001, 3'b010, 3'b110};
        ord[3] = {4'b0001, 3'b011, 3'b001};
        do_reset();
        issued.delete();
        for (int i = 0; i < 4; i++) cyc(1'b1, ord[i][9:6], ord[i][5:3], ord[i][2:0], 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) idle_cyc(1'b1, 1'b0);
        chk("order_pulses", issued.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < issued.size()) chk($sformatf("order%0d", i), 32'(issued[i]), 32'(ord[i]));
        chk("order_idle", {busy, count}, 0);

        // ---- full / overflow ----
        do_reset();
        issued.delete();
        for (int i = 0; i < 9; i++) cyc(1'b1, 4'(i + 1), 3'(i), 3'(i), 1'b0, 1'b0);
        chk("full_at_8", {full, count, overflow}, {1'b1, 4'd8, 1'b0});
        cyc(1'b1, 4'hA, 3'd1, 3'd1, 1'b0, 1'b0);
        chk("overflow_set", {full, count, overflow}, {1'b1, 4'd8, 1'b1});
        chk("ovf_one_issued", {issued.size() == 1, busy, func}, {1'b1, 1'b1, 4'd1});
        idle_cyc(1'b0, 1'b1);
        chk("ovf_cleared", overflow, 0);
        cyc(1'b1, 4'hB, 3'd2, 3'd2, 1'b0, 1'b1);
        chk("ovf_beats_clear", overflow, 1);
        idle_cyc(1'b0, 1'b1);
        chk("ovf_cleared2", overflow, 0);

        // ---- timeout, then next queued instruction, then done vs timeout ----
        do_reset();
        cyc(1'b1, 4'h6, 3'd1, 3'd2, 1'b0, 1'b0);
        cyc(1'b1, 4'h7, 3'd3, 3'd4, 1'b0, 1'b0);
        idle_cyc(1'b0, 1'b0); // now in WAIT
        n = 0;
        while (timeout_err !== 1'b1 && n < 40) begin
            idle_cyc(1'b0, 1'b0);
            n++;
        end
        chk("timeout_cycles", n, TIMEOUT);
        chk("timeout_outputs", {func, input1, input2, busy}, 0);
        idle_cyc(1'b0, 1'b0);
        chk("after_timeout_issue", {issue_valid, func, input1, input2}, {1'b1, 4'h7, 3'd3, 3'd4});
        idle_cyc(1'b0, 1'b1); // enter WAIT, clear error
        chk("terr_cleared", timeout_err, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) idle_cyc(1'b0, 1'b0);
        chk("still_waiting", {busy, timeout_err}, {1'b1, 1'b0});
        idle_cyc(1'b1, 1'b0);
        chk("done_beats_timeout", {busy, timeout_err, func}, 0);

        // ---- reset during WAIT ----
        do_reset();
        cyc(1'b1, 4'h2, 3'd1, 3'd1, 1'b0, 1'b0);
        cyc(1'b1, 4'h3, 3'd2, 3'd2, 1'b0, 1'b0);
        cyc(1'b1, 4'h4, 3'd3, 3'd3, 1'b0, 1'b0);
        chk("pre_reset", {busy, count}, {1'b1, 4'd2});
        rst_n = 1'b0;
        idle_cyc(1'b0, 1'b0);
        chk("mid_reset", obs, 20'h00004);
        rst_n = 1'b1;
        idle_cyc(1'b1, 1'b0);
        chk("post_reset", obs, 20'h00004);

        // ---- random traffic against the model ----
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            dp = ((i / 300) % 2 == 0) ? 40 : 3;
            rst_n = ($urandom_range(0, 299) != 0);
            cyc($urandom_range(0, 99) < 50, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), $urandom_range(0, 99) < dp, $urandom_range(0, 99) < 4);
            chk($sformatf("rand%0d", i), 32'(obs), 32'(model_obs()));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
